hash_nonce_sequencer: RTL

//  Sequences the 3-byte hash core (counter/w_flops/mux/mod_x_k/abc_calculation/hash_final)

---
 rtl/hash_nonce_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hash_nonce_sequencer.sv
// hash_nonce_sequencer: walks the 3-byte hash core through a 16-bit nonce search.
// Each attempt loads the message, runs the core for HASH_LATENCY cycles, then
// compares the core hash against the target. Stops on the first hit or at MAX_NONCE.
// Optional feature: define HASH_NONCE_SEQ_ABORT_EN to add the abort_i input.
module hash_nonce_sequencer #(
    parameter int unsigned HASH_LATENCY = 34,
    parameter logic [15:0] MAX_NONCE    = 16'hFFFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
`ifdef HASH_NONCE_SEQ_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic [111:0] block_i,
    input  logic [15:0]  nonce_start_i,
    input  logic [23:0]  target_i,
    input  logic [23:0]  core_hash_i,
    output logic         core_ready_o,
    output logic [127:0] core_data_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         found_o,
    output logic [15:0]  nonce_o,
    output logic [23:0]  hash_o
);

    localparam int unsigned CntW = (HASH_LATENCY > 1) ? $clog2(HASH_LATENCY) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(HASH_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StCheck,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     nonce_q, nonce_d;        // nonce currently being hashed
    logic [23:0]     target_q, target_d;
    logic [CntW-1:0] cnt_q, cnt_d;            // RUN wait counter
    logic [127:0]    data_q, data_d;
    logic            found_q, found_d;
    logic [15:0]     nonce_out_q, nonce_out_d;
    logic [23:0]     hash_q, hash_d;
    logic            hit;
    logic            abort;

`ifdef HASH_NONCE_SEQ_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign hit = (core_hash_i < target_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            nonce_q     <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            found_q     <= 1'b0;
            nonce_out_q <= '0;
            hash_q      <= '0;
        end else begin
            state_q     <= state_d;
            nonce_q     <= nonce_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            found_q     <= found_d;
            nonce_out_q <= nonce_out_d;
            hash_q      <= hash_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        nonce_d     = nonce_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        found_d     = found_q;
        nonce_out_d = nonce_out_q;
        hash_d      = hash_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StLoad;
                    nonce_d     = nonce_start_i;
                    target_d    = target_i;
                    found_d     = 1'b0;
                    nonce_out_d = '0;
                    hash_d      = '0;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                // byte 14 = nonce[7:0], byte 15 = nonce[15:8]
                data_d  = {nonce_q, block_i};
                state_d = abort ? StDone : StRun;
            end
            StRun: begin
                if (abort) begin
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCheck: begin
                hash_d      = core_hash_i;
                nonce_out_d = nonce_q;
                if (abort) begin
                    // abort wins over a same-cycle hit
                    found_d = 1'b0;
                    state_d = StDone;
                end else if (hit) begin
                    found_d = 1'b1;
                    state_d = StDone;
                end else if (nonce_q >= MAX_NONCE) begin
                    // >= also covers a start nonce beyond MAX_NONCE: one attempt only
                    state_d = StDone;
                end else begin
                    nonce_d = nonce_q + 16'd1;
                    state_d = StLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state so ready drops with the async reset
    always_comb begin
        core_ready_o = (state_q == StRun) || (state_q == StCheck);
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StDone);
        core_data_o  = data_q;
        found_o      = found_q;
        nonce_o      = nonce_out_q;
        hash_o       = hash_q;
    end

endmodule
